path_sched: RTL and testbench

Job-level sequencer for the single-path Monte Carlo engine. It accepts a pricing job of N paths, prefetches each path's daily epsilon draws from the RNG into an 8-entry buffer, and issues a start pulse to the engine. It streams the buffered epsilons on consecutive cycles and collects the engine's daily prices. For every path it compares the final-day price against the strike and reports the in-the-money count when the job completes.

---
 rtl/path_sched.sv | 143 ++++++++++++++
 tb/tb_path_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_sched.sv
// path_sched: job-level sequencer for the single-path Monte Carlo engine.
// Prefetches 8 epsilons per path, streams them to the engine and counts in-the-money final prices.
module path_sched #(
   parameter int NUM_OF_DAYS = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_start,
   input  logic [CNT_W-1:0] num_paths,
   input  logic [11:0]      strike,
   output logic             job_busy,
   output logic             job_done,
   output logic [CNT_W-1:0] itm_count,
   output logic [CNT_W-1:0] paths_done,
   input  logic             rng_valid,
   output logic             rng_ready,
   input  logic [12:0]      rng_eps,
   output logic             eng_start,
   output logic [12:0]      eng_eps,
   input  logic             eng_valid,
   input  logic [11:0]      eng_path,
   output logic             smp_valid,
   output logic [2:0]       smp_day,
   output logic [11:0]      smp_price
);

   typedef enum logic [2:0] {IDLE, FILL, ISSUE, COLLECT, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] num_paths_q;
   logic [11:0]      strike_q;
   logic [12:0]      eps_buf [NUM_OF_DAYS];
   logic [2:0]       wr_idx;
   logic [2:0]       iss_idx;
   logic [2:0]       iss_nxt;
   logic [2:0]       day_cnt;
   logic [CNT_W-1:0] paths_nxt;

   always_comb begin
      iss_nxt   = iss_idx + 3'd1;
      paths_nxt = paths_done + 1'b1;
   end

   // Buffer holds no reset: its contents are only read after a full refill.
   always_ff @(posedge clk) begin
      if (state == FILL && rng_valid) eps_buf[wr_idx] <= rng_eps;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         num_paths_q <= '0;
         strike_q    <= '0;
         wr_idx      <= '0;
         iss_idx     <= '0;
         day_cnt     <= '0;
         job_busy    <= 1'b0;
         job_done    <= 1'b0;
         itm_count   <= '0;
         paths_done  <= '0;
         rng_ready   <= 1'b0;
         eng_start   <= 1'b0;
         eng_eps     <= '0;
         smp_valid   <= 1'b0;
         smp_day     <= '0;
         smp_price   <= '0;
      end else begin
         smp_valid <= eng_valid;
         smp_price <= eng_path;
         smp_day   <= day_cnt;
         eng_start <= 1'b0;
         job_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (job_start) begin
                  num_paths_q <= num_paths;
                  strike_q    <= strike;
                  itm_count   <= '0;
                  paths_done  <= '0;
                  wr_idx      <= '0;
                  day_cnt     <= '0;
                  job_busy    <= 1'b1;
                  if (num_paths == '0) begin
                     state    <= DONE;
                     job_done <= 1'b1;
                  end else begin
                     state     <= FILL;
                     rng_ready <= 1'b1;
                  end
               end
            end
            FILL: begin
               day_cnt <= '0;
               if (rng_valid) begin
                  wr_idx <= wr_idx + 3'd1;
                  if (wr_idx == 3'd7) begin
                     // Entry 0 is stable here, so the first epsilon launches with the start pulse.
                     state     <= ISSUE;
                     rng_ready <= 1'b0;
                     eng_start <= 1'b1;
                     eng_eps   <= eps_buf[3'd0];
                     iss_idx   <= '0;
                  end
               end
            end
            ISSUE: begin
               if (eng_valid) day_cnt <= day_cnt + 3'd1;
               if (iss_idx == 3'd7) begin
                  state   <= COLLECT;
                  eng_eps <= '0;
               end else begin
                  iss_idx <= iss_nxt;
                  eng_eps <= eps_buf[iss_nxt];
               end
            end
            COLLECT: begin
               if (eng_valid) begin
                  day_cnt <= day_cnt + 3'd1;
                  if (day_cnt == 3'd7) begin
                     paths_done <= paths_nxt;
                     if (eng_path > strike_q) itm_count <= itm_count + 1'b1;
                     if (paths_nxt == num_paths_q) begin
                        state    <= DONE;
                        job_done <= 1'b1;
                     end else begin
                        state     <= FILL;
                        rng_ready <= 1'b1;
                        wr_idx    <= '0;
                     end
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               job_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_path_sched.sv
// Self-checking bench for path_sched: RNG source, engine model and a per-job reference of
// transferred epsilons, final prices and expected in-the-money count.
module tb_path_sched;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             job_start = 1'b0;
   logic [CNT_W-1:0] num_paths = '0;
   logic [11:0]      strike = '0;
   logic             job_busy, job_done;
   logic [CNT_W-1:0] itm_count, paths_done;
   logic             rng_valid, rng_ready;
   logic [12:0]      rng_eps;
   logic             eng_start;
   logic [12:0]      eng_eps;
   logic             eng_valid;
   logic [11:0]      eng_path;
   logic             smp_valid;
   logic [2:0]       smp_day;
   logic [11:0]      smp_price;

   path_sched #(.NUM_OF_DAYS(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .job_start(job_start), .num_paths(num_paths), .strike(strike),
      .job_busy(job_busy), .job_done(job_done), .itm_count(itm_count), .paths_done(paths_done),
      .rng_valid(rng_valid), .rng_ready(rng_ready), .rng_eps(rng_eps),
      .eng_start(eng_start), .eng_eps(eng_eps), .eng_valid(eng_valid), .eng_path(eng_path),
      .smp_valid(smp_valid), .smp_day(smp_day), .smp_price(smp_price)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0, errors = 0;
   int          rng_mode = 0;
   int unsigned ready_cycles = 0, starts = 0, eps_bad = 0, smp_bad = 0, busy_bad = 0;
   logic [12:0] rng_src[$];
   logic [12:0] sent_q[$];
   logic [12:0] eps_seen[$];
   logic [11:0] final_q[$];
   int          eng_off = -1;
   int          pday = 0;
   logic [11:0] day_price [8];

   // RNG source: 1 = always valid, 2 = alternate cycles while ready, 3 = random
   initial begin
      rng_valid = 1'b0;
      rng_eps   = '0;
      forever begin
         @(negedge clk);
         if (rng_ready === 1'b1) ready_cycles++;
         case (rng_mode)
            1:       rng_valid = 1'b1;
            2:       rng_valid = (rng_ready === 1'b1) ? ~rng_valid : 1'b1;
            3:       rng_valid = 1'($urandom_range(0, 1));
            default: rng_valid = 1'b0;
         endcase
         if (rng_src.size() == 0) rng_src.push_back(13'($urandom));
         rng_eps = rng_src[0];
         if (rng_valid && rng_ready === 1'b1 && !rst) sent_q.push_back(rng_src.pop_front());
      end
   end

   // Engine: consumes eps at s..s+7, returns day-k price at s+3+k
   initial begin
      eng_valid = 1'b0;
      eng_path  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            eng_off   = -1;
            eng_valid = 1'b0;
            eng_path  = '0;
         end else begin
            if (smp_valid !== eng_valid ||
                (eng_valid && (smp_price !== eng_path || smp_day !== 3'(pday)))) smp_bad++;
            if (eng_start === 1'b1) begin
               starts++;
               eng_off = 0;
               for (int d = 0; d < 8; d++) day_price[d] = 12'($urandom);
               if (final_q.size() > 0) day_price[7] = final_q.pop_front();
            end else if (eng_off >= 0) begin
               eng_off++;
            end
            if (eng_off >= 0 && eng_off <= 7) eps_seen.push_back(eng_eps);
            else if (eng_eps !== '0) eps_bad++;
            if (eng_off >= 3 && eng_off <= 10) begin
               pday      = eng_off - 3;
               eng_valid = 1'b1;
               eng_path  = day_price[pday];
            end else begin
               eng_valid = 1'b0;
               eng_path  = 12'($urandom);
            end
            if (eng_off >= 10) eng_off = -1;
         end
      end
   end

   // Runs one job; lat counts cycles from acceptance to job_done, inj injects a stray job_start
   task automatic do_job(input int unsigned n, input logic [11:0] stk, input int unsigned inj,
                         output int unsigned lat, output int unsigned dones);
      int unsigned budget;
      budget = 80 * n + 40;
      starts = 0; eps_bad = 0; smp_bad = 0; busy_bad = 0; ready_cycles = 0;
      eps_seen.delete();
      sent_q.delete();
      @(negedge clk);
      job_start = 1'b1; num_paths = CNT_W'(n); strike = stk;
      @(negedge clk);
      job_start = 1'b0; num_paths = CNT_W'($urandom_range(1, 7)); strike = 12'($urandom);
      lat = 1;
      dones = 0;
      if (job_busy !== 1'b1) busy_bad++;
      while (job_done !== 1'b1 && lat < budget) begin
         @(negedge clk);
         lat++;
         job_start = (lat == inj);
         if (lat == inj) begin num_paths = 16'd1; strike = 12'h000; end
         if (job_busy !== 1'b1) busy_bad++;
      end
      job_start = 1'b0;
      if (job_done === 1'b1) dones = 1;
      repeat (3) begin
         @(negedge clk);
         if (job_done === 1'b1) dones++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (job_busy !== 1'b0)   begin errors++; $display("FAIL reset_job_busy: got %b want 0", job_busy); end
      checks++; if (job_done !== 1'b0)   begin errors++; $display("FAIL reset_job_done: got %b want 0", job_done); end
      checks++; if (itm_count !== '0)    begin errors++; $display("FAIL reset_itm: got %0h want 0", itm_count); end
      checks++; if (paths_done !== '0)   begin errors++; $display("FAIL reset_paths: got %0h want 0", paths_done); end
      checks++; if (rng_ready !== 1'b0)  begin errors++; $display("FAIL reset_rng_ready: got %b want 0", rng_ready); end
      checks++; if (eng_start !== 1'b0)  begin errors++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
      checks++; if (eng_eps !== '0)      begin errors++; $display("FAIL reset_eng_eps: got %0h want 0", eng_eps); end
      checks++; if (smp_valid !== 1'b0)  begin errors++; $display("FAIL reset_smp_valid: got %b want 0", smp_valid); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_path();
      int unsigned lat, dones;
      rng_mode = 1;
      rng_src.delete();
      for (int i = 1; i <= 8; i++) rng_src.push_back(13'(i));
      final_q.delete();
      final_q.push_back(12'h400);
      do_job(1, 12'h3FF, 0, lat, dones);
      checks++; if (eps_seen.size() != 8) begin errors++; $display("FAIL single_eps_count: got %0d want 8", eps_seen.size()); end
      for (int i = 0; i < 8 && i < eps_seen.size(); i++) begin
         logic [12:0] want;
         want = 13'(i + 1);
         checks++; if (eps_seen[i] !== want) begin errors++; $display("FAIL single_eps[%0d]: got %0h want %0h", i, eps_seen[i], want); end
      end
      checks++; if (itm_count !== 16'd1)  begin errors++; $display("FAIL single_itm: got %0d want 1", itm_count); end
      checks++; if (paths_done !== 16'd1) begin errors++; $display("FAIL single_paths: got %0d want 1", paths_done); end
      checks++; if (starts != 1)          begin errors++; $display("FAIL single_starts: got %0d want 1", starts); end
      checks++; if (dones != 1)           begin errors++; $display("FAIL single_done_pulses: got %0d want 1", dones); end
      checks++; if (lat != 20)            begin errors++; $display("FAIL single_latency: got %0d want 20", lat); end
      checks++; if (ready_cycles != 8)    begin errors++; $display("FAIL single_fill_cycles: got %0d want 8", ready_cycles); end
      checks++; if (eps_bad != 0)         begin errors++; $display("FAIL single_eps_idle: got %0d want 0", eps_bad); end
      checks++; if (smp_bad != 0)         begin errors++; $display("FAIL single_smp: got %0d want 0", smp_bad); end
      checks++; if (busy_bad != 0)        begin errors++; $display("FAIL single_busy: got %0d want 0", busy_bad); end
      checks++; if (job_busy !== 1'b0)    begin errors++; $display("FAIL single_busy_after: got %b want 0", job_busy); end
   endtask

   task automatic test_zero_paths();
      int unsigned lat, dones;
      do_job(0, 12'h001, 0, lat, dones);
      checks++; if (lat != 1)             begin errors++; $display("FAIL zero_done_latency: got %0d want 1", lat); end
      checks++; if (dones != 1)           begin errors++; $display("FAIL zero_done_pulses: got %0d want 1", dones); end
      checks++; if (itm_count !== '0)     begin errors++; $display("FAIL zero_itm: got %0d want 0", itm_count); end
      checks++; if (paths_done !== '0)    begin errors++; $display("FAIL zero_paths: got %0d want 0", paths_done); end
      checks++; if (ready_cycles != 0)    begin errors++; $display("FAIL zero_rng_ready: got %0d want 0", ready_cycles); end
      checks++; if (starts != 0)          begin errors++; $display("FAIL zero_starts: got %0d want 0", starts); end
   endtask

   // Generic randomized job checked against the reference count of finals above the strike
   task automatic run_checked(input string name, input int unsigned n, input logic [11:0] stk,
                              input int unsigned inj, input logic [11:0] finals[$]);
      int unsigned lat, dones, exp_itm;
      exp_itm = 0;
      final_q.delete();
      foreach (finals[i]) begin
         final_q.push_back(finals[i]);
         if (finals[i] > stk) exp_itm++;
      end
      do_job(n, stk, inj, lat, dones);
      checks++; if (itm_count !== CNT_W'(exp_itm)) begin errors++; $display("FAIL %s_itm: got %0d want %0d", name, itm_count, exp_itm); end
      checks++; if (paths_done !== CNT_W'(n))      begin errors++; $display("FAIL %s_paths: got %0d want %0d", name, paths_done, n); end
      checks++; if (starts != n)     begin errors++; $display("FAIL %s_starts: got %0d want %0d", name, starts, n); end
      checks++; if (dones != 1)      begin errors++; $display("FAIL %s_done_pulses: got %0d want 1", name, dones); end
      checks++; if (eps_seen.size() != 8 * n) begin errors++; $display("FAIL %s_eps_count: got %0d want %0d", name, eps_seen.size(), 8 * n); end
      for (int i = 0; i < eps_seen.size() && i < sent_q.size(); i++) begin
         checks++; if (eps_seen[i] !== sent_q[i]) begin errors++; $display("FAIL %s_eps[%0d]: got %0h want %0h", name, i, eps_seen[i], sent_q[i]); end
      end
      checks++; if (eps_bad != 0 || smp_bad != 0 || busy_bad != 0) begin
         errors++; $display("FAIL %s_monitors: eps_idle %0d smp %0d busy %0d want all 0", name, eps_bad, smp_bad, busy_bad);
      end
   endtask

   task automatic test_multi_path();
      logic [11:0] fin[$];
      fin = '{12'h300, 12'h500, 12'h3FF};
      rng_mode = 3;
      run_checked("multi", 3, 12'h3FF, 0, fin);
   endtask

   task automatic test_toggle();
      logic [11:0] fin[$];
      logic [12:0] exp_eps[$];
      rng_mode = 2;
      rng_src.delete();
      exp_eps.push_back(13'h1ABC);
      for (int i = 1; i < 8; i++) exp_eps.push_back({1'(i % 2), 12'($urandom)});
      foreach (exp_eps[i]) rng_src.push_back(exp_eps[i]);
      fin.push_back(12'($urandom));
      run_checked("toggle", 1, 12'($urandom), 0, fin);
      checks++; if (ready_cycles != 16) begin errors++; $display("FAIL toggle_fill_cycles: got %0d want 16", ready_cycles); end
      for (int i = 0; i < 8 && i < eps_seen.size(); i++) begin
         checks++; if (eps_seen[i] !== exp_eps[i]) begin errors++; $display("FAIL toggle_order[%0d]: got %0h want %0h", i, eps_seen[i], exp_eps[i]); end
      end
   endtask

   task automatic test_start_during_collect();
      logic [11:0] fin[$];
      rng_mode = 1;
      fin = '{12'($urandom), 12'($urandom)};
      run_checked("collect_start", 2, 12'($urandom_range(12'h100, 12'hEFF)), 17, fin);
   endtask

   task automatic test_random_jobs();
      for (int j = 0; j < 4; j++) begin
         logic [11:0] fin[$];
         int unsigned n;
         n = $urandom_range(1, 4);
         rng_mode = $urandom_range(1, 3);
         for (int p = 0; p < n; p++) fin.push_back(12'($urandom));
         run_checked("random", n, 12'($urandom), 0, fin);
      end
   endtask

   task automatic test_reset_mid_issue();
      int unsigned waited;
      logic [11:0] fin[$];
      rng_mode = 1;
      final_q.delete();
      @(negedge clk);
      job_start = 1'b1; num_paths = 16'd1; strike = 12'($urandom);
      @(negedge clk);
      job_start = 1'b0;
      waited = 0;
      while (eng_start !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
      checks++; if (waited >= 40) begin errors++; $display("FAIL rst_issue_start_seen: got timeout want eng_start"); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL rst_issue_eng_start: got %b want 0", eng_start); end
      checks++; if (job_busy !== 1'b0)  begin errors++; $display("FAIL rst_issue_busy: got %b want 0", job_busy); end
      checks++; if (rng_ready !== 1'b0) begin errors++; $display("FAIL rst_issue_rng_ready: got %b want 0", rng_ready); end
      checks++; if (itm_count !== '0)   begin errors++; $display("FAIL rst_issue_itm: got %0d want 0", itm_count); end
      checks++; if (eng_eps !== '0)     begin errors++; $display("FAIL rst_issue_eng_eps: got %0h want 0", eng_eps); end
      repeat (2) @(negedge clk);
      checks++; if (job_busy !== 1'b0 || rng_ready !== 1'b0 || eng_start !== 1'b0) begin
         errors++; $display("FAIL rst_issue_hold: busy %b ready %b start %b want 0 0 0", job_busy, rng_ready, eng_start);
      end
      rst = 1'b0;
      fin.push_back(12'h800);
      run_checked("after_rst", 1, 12'h7FF, 0, fin);
   endtask

   initial begin
      test_reset();
      test_single_path();
      test_zero_paths();
      test_multi_path();
      test_toggle();
      test_start_during_collect();
      test_random_jobs();
      test_reset_mid_issue();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
